// File: rtl/add64_accum_seq.sv
// add64_accum_seq
//    Multi-operand accumulator in front of a 64-bit carry-select adder. It takes a
//    job of `len` operands over a valid/ready stream. Each operand goes through the
//    adder together with the running sum, and the final sum is presented on a
//    valid/ready result port. In subtract mode the first operand is the minuend and
//    every later operand is subtracted from it.
//
//    State table
//    state   | meaning
//    --------+----------------------------------------------------------
//    S_IDLE  | waiting for start; no operand or result traffic
//    S_ACCUM | accepting operands, one per cycle, until `remaining` is spent
//    S_HOLD  | result presented on out_*; held until out_ready
//
// Ports
//    clk        rising-edge clock
//    rst        synchronous reset, active-high
//    start      begin a job (looked at only in S_IDLE)
//    len        operand count for the job, captured with start
//    sub        0 = sum all operands, 1 = first minus the rest; captured with start
//    in_valid   operand present on in_data
//    in_ready   operand accepted this cycle when in_valid is also high
//    in_data    64-bit operand
//    out_valid  result available
//    out_ready  consumer takes the result
//    out_sum    accumulated result (0 when out_valid=0)
//    out_flag   sticky overflow (add) / borrow (sub) flag (0 when out_valid=0)
//    out_count  operands accepted in this job (0 when out_valid=0)
//    busy       high whenever not in S_IDLE

module add64_accum_seq #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_sum,
   output logic             out_flag,
   output logic [CNT_W-1:0] out_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam int BLK  = 16;
   localparam int NBLK = 64 / BLK;

   state_t           state, state_nxt;
   logic [63:0]      acc;
   logic             flag;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] remaining;
   logic             sub_mode;

   logic             accept;
   logic             first_op;
   logic             invert;
   logic [63:0]      add_b;
   logic [63:0]      add_sum;
   logic             add_cout;
   logic [NBLK:0]    blk_c;

   assign accept   = (state == S_ACCUM) && in_valid;
   assign first_op = (count == '0);
   // The first operand always loads as-is (acc is 0). Only later operands get
   // two's-complement negation in subtract mode.
   assign invert   = sub_mode && !first_op;
   assign add_b    = invert ? ~in_data : in_data;

   // Carry-select adder: each 16-bit block precomputes its sum for carry-in 0
   // and for carry-in 1. The ripple between blocks is only a mux chain.
   assign blk_c[0] = invert;

   for (genvar k = 0; k < NBLK; k++) begin : g_csel
      logic [BLK-1:0] a_k;
      logic [BLK-1:0] b_k;
      logic [BLK:0]   s_c0;
      logic [BLK:0]   s_c1;

      assign a_k  = acc[k*BLK +: BLK];
      assign b_k  = add_b[k*BLK +: BLK];
      assign s_c0 = {1'b0, a_k} + {1'b0, b_k};
      assign s_c1 = {1'b0, a_k} + {1'b0, b_k} + {{BLK{1'b0}}, 1'b1};

      assign add_sum[k*BLK +: BLK] = blk_c[k] ? s_c1[BLK-1:0] : s_c0[BLK-1:0];
      assign blk_c[k+1]            = blk_c[k] ? s_c1[BLK]     : s_c0[BLK];
   end

   assign add_cout = blk_c[NBLK];

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (len == '0) ? S_HOLD : S_ACCUM;
         end
         S_ACCUM: begin
            if (accept && (remaining == CNT_W'(1))) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_sum   = '0;
      out_flag  = 1'b0;
      out_count = '0;
      busy      = (state != S_IDLE);
      case (state)
         S_ACCUM: in_ready = 1'b1;
         S_HOLD: begin
            out_valid = 1'b1;
            out_sum   = acc;
            out_flag  = flag;
            out_count = count;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         flag      <= 1'b0;
         count     <= '0;
         remaining <= '0;
         sub_mode  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc       <= '0;
                  flag      <= 1'b0;
                  count     <= '0;
                  remaining <= len;
                  sub_mode  <= sub;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  acc       <= add_sum;
                  count     <= count + CNT_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  // Carry out means overflow when adding. No carry out means
                  // a borrow when subtracting.
                  if (!first_op) flag <= flag | (sub_mode ? ~add_cout : add_cout);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add64_accum_seq.sv
module tb_add64_accum_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        sub;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_sum;
   logic        out_flag;
   logic [7:0]  out_count;
   logic        busy;

   add64_accum_seq #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_flag(out_flag), .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int acc_cnt = 0;

   logic [63:0] ops [256];
   logic [63:0] exp_sum = '0;
   logic        exp_flag = 1'b0;
   logic [7:0]  exp_count = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: the result of the job is plain 64-bit arithmetic over the operand list.
   // Overflow shows up as a 65th bit. A borrow happens when the subtrahend exceeds the running value.
   task automatic model_job(input int n, input bit s);
      logic [63:0] a;
      logic [64:0] w;
      logic        f;
      a = '0;
      f = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == 0) a = ops[0];
         else if (!s) begin
            w = {1'b0, a} + {1'b0, ops[i]};
            if (w[64]) f = 1'b1;
            a = w[63:0];
         end else begin
            if (ops[i] > a) f = 1'b1;
            a = a - ops[i];
         end
      end
      exp_sum   = a;
      exp_flag  = f;
      exp_count = 8'(n);
   endtask

   // Output checker: a presented result must match the model, and the outputs must be 0 otherwise.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         check("out_sum",   out_sum,          out_valid ? exp_sum : 64'h0);
         check("out_flag",  64'(out_flag),    out_valid ? 64'(exp_flag) : 64'h0);
         check("out_count", 64'(out_count),   out_valid ? 64'(exp_count) : 64'h0);
         check("busy_consistent", 64'(busy), 64'(in_ready | out_valid));
         check("ready_valid_exclusive", 64'(in_ready & out_valid), 64'h0);
         if (in_valid && in_ready) acc_cnt++;
      end
   end

   // Call at posedge+1. Returns at posedge+1 with the block back in idle.
   task automatic run_job(input int n, input bit s, input int gap, input int hold);
      int  base;
      bit  got;
      model_job(n, s);
      base  = acc_cnt;
      start = 1'b1;
      len   = 8'(n);
      sub   = s;
      @(posedge clk); #1;
      start = 1'b0;
      len   = 8'hA5;
      sub   = ~s;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = ops[i];
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         check("accept_wait", 64'(got), 64'h1);
         @(posedge clk); #1;
      end
      // Keep offering data to show that the held result blocks further accepts.
      in_valid = 1'b1;
      in_data  = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      check("out_valid_latency", 64'(out_valid), 64'h1);
      check("in_ready_in_hold", 64'(in_ready), 64'h0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         start = 1'b1;
         len   = 8'h03;
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'h1);
         check("hold_busy", 64'(busy), 64'h1);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("idle_after_handshake", 64'(busy), 64'h0);
      check("accept_count", 64'(acc_cnt - base), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      rst = 1'b1; start = 1'b1; len = 8'd3; sub = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_in_ready", 64'(in_ready), 64'h0);
      check("reset_out_valid", 64'(out_valid), 64'h0);
      @(posedge clk); #1;

      // add chain
      ops[0] = 64'd1; ops[1] = 64'd2; ops[2] = 64'd3;
      model_job(3, 1'b0);
      check("pin_add_sum", exp_sum, 64'd6);
      run_job(3, 1'b0, 0, 0);

      // overflow, then a fresh job clears the flag
      ops[0] = 64'hFFFF_FFFF_FFFF_FFFF; ops[1] = 64'h1;
      model_job(2, 1'b0);
      check("pin_ovf_sum", exp_sum, 64'h0);
      check("pin_ovf_flag", 64'(exp_flag), 64'h1);
      run_job(2, 1'b0, 0, 0);
      ops[0] = 64'd5;
      run_job(1, 1'b0, 0, 0);

      // subtract without and with borrow
      ops[0] = 64'd10; ops[1] = 64'd3;
      model_job(2, 1'b1);
      check("pin_sub_sum", exp_sum, 64'd7);
      run_job(2, 1'b1, 0, 0);
      ops[0] = 64'd3; ops[1] = 64'd10;
      model_job(2, 1'b1);
      check("pin_borrow_sum", exp_sum, 64'hFFFF_FFFF_FFFF_FFF9);
      check("pin_borrow_flag", 64'(exp_flag), 64'h1);
      run_job(2, 1'b1, 0, 0);

      // empty job held under backpressure while start pulses
      run_job(0, 1'b0, 0, 5);

      // input gaps
      for (int i = 0; i < 4; i++) ops[i] = 64'h10;
      model_job(4, 1'b0);
      check("pin_gap_sum", exp_sum, 64'h40);
      run_job(4, 1'b0, 2, 0);

      // mixed subtract chain with random operands
      for (int i = 0; i < 6; i++) ops[i] = {32'($urandom), 32'($urandom)};
      run_job(6, 1'b1, 1, 1);

      // maximum-length add job (count reaches 255)
      for (int i = 0; i < 255; i++) ops[i] = {32'($urandom), 32'($urandom)};
      run_job(255, 1'b0, 0, 0);

      // reset mid-job
      base  = acc_cnt;
      start = 1'b1; len = 8'd5; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = 64'h11;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'h0);
      check("abort_in_ready", 64'(in_ready), 64'h0);
      check("abort_out_valid", 64'(out_valid), 64'h0);
      check("abort_accepts", 64'(acc_cnt - base), 64'h2);
      @(posedge clk); #1;
      ops[0] = 64'd7;
      model_job(1, 1'b0);
      check("pin_after_reset_sum", exp_sum, 64'd7);
      run_job(1, 1'b0, 0, 0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/add64_accum_seq.md
Name: add64_accum_seq

Overview:
- Sequential accumulator that streams up to 255 64-bit operands through one CSA_64bit instance and returns the running sum.
- Sits directly upstream of the 64-bit carry-select adder. It sequences the adder's A/B/Cin inputs and registers its Sum/Cout, which turns the combinational adder into a multi-operand add/subtract engine.
- Valid/ready handshake on the operand input and on the result output.

Parameters:
- CNT_W, 8, width of operand-count fields; max operands = 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a job; sampled only in IDLE.
- len  input  CNT_W  number of operands in the job, sampled with start.
- sub  input  1  mode, sampled with start: 0 = add all operands; 1 = first operand minus all later ones.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  64  operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  64  accumulated result.
- out_flag  output  1  sticky flag. Add mode: any adder Cout=1 (unsigned overflow). Sub mode: any subtract step with Cout=0 (borrow).
- out_count  output  CNT_W  operands accepted in this job.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE, acc=0, flag=0, count=0, remaining=0. All outputs 0. Applies in any state; an in-progress job is discarded with no partial result.
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=0, out_valid=0.
  - start=1, len=0: acc=0, flag=0, count=0, go to HOLD.
  - start=1, len>0: acc=0, flag=0, count=0, remaining=len, latch sub, go to ACCUM.
- ACCUM: in_ready=1. On in_valid=1 (accept):
  - Adder A=acc.
  - First operand (count==0): B=in_data, Cin=0; Cout is ignored for the flag.
  - Later operands, add mode: B=in_data, Cin=0; flag |= Cout.
  - Later operands, sub mode: B=~in_data, Cin=1; flag |= ~Cout.
  - acc <= adder Sum; count++; remaining--.
  - If remaining==1 at accept, go to HOLD.
  - No accept: state unchanged.
- HOLD: out_valid=1; out_sum=acc, out_flag=flag, out_count=count, all stable.
  - out_ready=1: go to IDLE.
  - out_ready=0: hold indefinitely.
- Throughput and latency:
  - One operand per cycle; the adder path is single-cycle combinational from acc/in_data to the acc register.
  - out_valid rises the cycle after the last operand is accepted.
  - len=0: out_valid the cycle after start.
- Boundary rules:
  - start outside IDLE is ignored; len/sub changes outside IDLE have no effect.
  - in_valid outside ACCUM is not accepted (in_ready=0).
  - Wrap-around: acc wraps modulo 2^64; flag records it.
  - No back-to-back accept after the final operand: in_ready=0 in the cycle the result is presented.
  - Back-to-back jobs: earliest start sample is the cycle after the out_valid&&out_ready handshake (IDLE costs one cycle).
  - rst and start asserted together: rst wins.
- out_sum, out_flag and out_count read as 0 whenever out_valid=0.

Test Plan:
- Add chain: start, len=3, sub=0; operands 1, 2, 3 back-to-back -> out_valid 1 cycle after the 3rd accept; out_sum=6, out_flag=0, out_count=3.
- Overflow: len=2, add; operands 0xFFFF_FFFF_FFFF_FFFF, 0x1 -> out_sum=0, out_flag=1. Then a new job len=1, operand 5 -> out_sum=5, out_flag=0 (flag cleared per job).
- Subtract with borrow:
  - sub=1, len=2; operands 10, 3 -> out_sum=7, out_flag=0.
  - sub=1, len=2; operands 3, 10 -> out_sum=0xFFFF_FFFF_FFFF_FFF9, out_flag=1.
- Empty job and backpressure:
  - len=0 -> out_valid next cycle; out_sum=0, out_count=0.
  - Hold out_ready=0 for 5 cycles while pulsing start=1 -> outputs unchanged, start ignored. Then out_ready=1 -> IDLE.
- Input gaps: len=4, operands 0x10 each with in_valid low 2 cycles between them -> exactly 4 accepts, out_sum=0x40, out_count=4, no extra accepts.
- Reset mid-job: len=5, accept 2 operands, assert rst for 1 cycle -> next cycle busy=0, in_ready=0, out_valid=0. Then start len=1, operand 7 -> out_sum=7, out_count=1.
